z80_ctl_stim: RTL



---
 rtl/z80_stim_pkg.sv | 26 ++
 rtl/z80_stim_chan.sv | 126 ++++++++++++
 rtl/z80_ctl_stim.sv | 91 +++++++++
 3 files changed

// File: rtl/z80_stim_pkg.sv
// Shared types and constants for the Z80 control-input stimulus generator.
// Optional feature macro: Z80_STIM_JITTER_EN (LFSR-based gap jitter).
package z80_stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        ASSERT,
        GAP,
        DONE
    } stim_state_t;

    localparam logic [1:0] CFG_DELAY  = 2'd0;
    localparam logic [1:0] CFG_WIDTH  = 2'd1;
    localparam logic [1:0] CFG_PERIOD = 2'd2;
    localparam logic [1:0] CFG_JITTER = 2'd3;

    // x^8 + x^6 + x^5 + x^4 + 1, shifted left, feedback from bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/z80_stim_chan.sv
// One stimulus channel: delay, active-low pulse, optional periodic gap.
// A jitter term (zero when Z80_STIM_JITTER_EN is undefined) stretches each gap.
module z80_stim_chan
    import z80_stim_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    input  logic [7:0]       jit,
    output logic             out_n,
    output logic             busy,
    output logic             done
);

    // One spare bit so gap + jitter never wraps
    localparam int unsigned CW = CNT_W + 1;

    stim_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    gap_base, gap_load;
    logic [CNT_W-1:0] w_q, w_d, p_q, p_d;
    logic             out_n_q, out_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Gap length loaded at the end of each pulse in periodic mode
    always_comb begin
        gap_base = (p_q > w_q) ? {1'b0, p_q - w_q} : CW'(1);
        gap_load = gap_base + CW'(jit);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        p_d     = p_q;
        out_n_d = out_n_q;
        busy_d  = busy_q;
        done_d  = done_q;
        if (stop) begin
            state_d = IDLE;
            out_n_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = DELAY;
                        cnt_d   = {1'b0, delay};
                        w_d     = (width == '0) ? CNT_W'(1) : width;
                        p_d     = period;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end
                DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ASSERT;
                        out_n_d = 1'b0;
                        cnt_d   = {1'b0, w_q};
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ASSERT: begin
                    if (cnt_q <= CW'(1)) begin
                        out_n_d = 1'b1;
                        if (p_q == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = GAP;
                            cnt_d   = gap_load;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = ASSERT;
                        out_n_d = 1'b0;
                        cnt_d   = {1'b0, w_q};
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            p_q     <= '0;
            out_n_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            p_q     <= p_d;
            out_n_q <= out_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_n = out_n_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: rtl/z80_ctl_stim.sv
// Programmable generator for the Z80 active-low control inputs.
// Holds per-channel config registers and instantiates one FSM per channel.
// Optional macro Z80_STIM_JITTER_EN adds a shared LFSR and per-channel jitter masks.
module z80_ctl_stim
    import z80_stim_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int CNT_W  = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [CNT_W-1:0]          cfg_data,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         stop,
    output logic [NUM_CH-1:0]         out_n,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done
);

    logic [CNT_W-1:0] delay_q  [NUM_CH];
    logic [CNT_W-1:0] width_q  [NUM_CH];
    logic [CNT_W-1:0] period_q [NUM_CH];
    logic [7:0]       jit      [NUM_CH];
    logic             cfg_ok;

    // Writes to a non-existent channel are dropped
    assign cfg_ok = cfg_we && (int'(cfg_ch) < NUM_CH);

`ifdef Z80_STIM_JITTER_EN
    logic [7:0] lfsr_q;
    logic [7:0] mask_q [NUM_CH];

    // Free-running shared LFSR
    always_ff @(posedge CLK) begin
        if (RESET) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_next(lfsr_q);
    end
`endif

    // Config register file; a running channel keeps its latched copy
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NUM_CH; i++) begin
                delay_q[i]  <= '0;
                width_q[i]  <= '0;
                period_q[i] <= '0;
`ifdef Z80_STIM_JITTER_EN
                mask_q[i]   <= '0;
`endif
            end
        end else if (cfg_ok) begin
            case (cfg_sel)
                CFG_DELAY:  delay_q[cfg_ch]  <= cfg_data;
                CFG_WIDTH:  width_q[cfg_ch]  <= cfg_data;
                CFG_PERIOD: period_q[cfg_ch] <= cfg_data;
`ifdef Z80_STIM_JITTER_EN
                CFG_JITTER: mask_q[cfg_ch]   <= cfg_data[7:0];
`endif
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
`ifdef Z80_STIM_JITTER_EN
        assign jit[g] = lfsr_q & mask_q[g];
`else
        assign jit[g] = 8'h00;
`endif

        z80_stim_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .CLK    (CLK),
            .RESET  (RESET),
            .start  (start[g]),
            .stop   (stop[g]),
            .delay  (delay_q[g]),
            .width  (width_q[g]),
            .period (period_q[g]),
            .jit    (jit[g]),
            .out_n  (out_n[g]),
            .busy   (busy[g]),
            .done   (done[g])
        );
    end

endmodule
